// File: rtl/fetch_issue_unit_pkg.sv
// Shared pipeline definitions: NOP encoding, fetch FSM states and opcode field position.
package fetch_issue_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_issue_unit_if.sv
// Instruction memory bus: one outstanding request, response strobe with no backpressure.
interface fetch_issue_unit_if #(
    parameter int PC_W = 12
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_hold_buf.sv
// Single-entry parking register for a fetched word that arrives while decode is stalled.
module fetch_hold_buf
    import fetch_issue_unit_pkg::*;
#(
    parameter int PC_W = 12
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            load,
    input  logic            clear,
    input  logic [31:0]     ir_in,
    input  logic [PC_W-1:0] pc_in,
    output logic [31:0]     ir,
    output logic [PC_W-1:0] pc,
    output logic            full
);

    logic [31:0]     ir_reg;
    logic [PC_W-1:0] pc_reg;
    logic            full_reg;

    // Clear wins so a redirect always empties the buffer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ir_reg   <= NOP_INSTR;
            pc_reg   <= '0;
            full_reg <= 1'b0;
        end else if (clear) begin
            ir_reg   <= NOP_INSTR;
            pc_reg   <= '0;
            full_reg <= 1'b0;
        end else if (load) begin
            ir_reg   <= ir_in;
            pc_reg   <= pc_in;
            full_reg <= 1'b1;
        end
    end

    assign ir   = ir_reg;
    assign pc   = pc_reg;
    assign full = full_reg;

endmodule

// File: rtl/fetch_issue_unit.sv
// Fetch/issue stage: owns the PC, hides imem latency and decode stalls, fills the F/D latch.
module fetch_issue_unit
    import fetch_issue_unit_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    fetch_issue_unit_if.master imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [31:0]        fd_ir,
    output logic [PC_W-1:0]    fd_pc,
    output logic               fd_valid
);

    fetch_state_t    state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [31:0]     fd_ir_reg, fd_ir_next;
    logic [PC_W-1:0] fd_pc_reg, fd_pc_next;
    logic            fd_valid_reg, fd_valid_next;
    logic            squash_reg, squash_next;

    logic            req;
    logic            hb_load, hb_clear, hb_full;
    logic [31:0]     hb_ir;
    logic [PC_W-1:0] hb_pc;
    logic [PC_W-1:0] pc_inc, pc_prev;

    assign pc_inc  = pc_reg + {{(PC_W-1){1'b0}}, 1'b1};
    // pc already points past the outstanding request, so its address is pc-1.
    assign pc_prev = pc_reg - {{(PC_W-1){1'b0}}, 1'b1};

    fetch_hold_buf #(.PC_W(PC_W)) u_hold_buf (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (hb_load),
        .clear   (hb_clear),
        .ir_in   (imem.imem_rdata),
        .pc_in   (pc_prev),
        .ir      (hb_ir),
        .pc      (hb_pc),
        .full    (hb_full)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_START;
            pc_reg       <= RESET_PC;
            fd_ir_reg    <= NOP_INSTR;
            fd_pc_reg    <= '0;
            fd_valid_reg <= 1'b0;
            squash_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            fd_ir_reg    <= fd_ir_next;
            fd_pc_reg    <= fd_pc_next;
            fd_valid_reg <= fd_valid_next;
            squash_reg   <= squash_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        squash_next   = squash_reg;
        fd_ir_next    = fd_ir_reg;
        fd_pc_next    = fd_pc_reg;
        fd_valid_next = fd_valid_reg;
        hb_load       = 1'b0;
        hb_clear      = 1'b0;
        req           = 1'b0;

        if (redirect) begin
            fd_ir_next    = NOP_INSTR;
            fd_valid_next = 1'b0;
            pc_next       = redirect_pc;
            hb_clear      = 1'b1;
            // A request still in flight must be drained before the target can be fetched.
            if (state_reg == ST_WAIT && !imem.imem_valid) begin
                squash_next = 1'b1;
            end else begin
                squash_next = 1'b0;
                state_next  = ST_REQ;
            end
        end else begin
            case (state_reg)
                ST_START: state_next = ST_REQ;
                ST_REQ: begin
                    req        = 1'b1;
                    pc_next    = pc_inc;
                    state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (!imem.imem_valid) begin
                        if (!stall) begin
                            fd_ir_next    = NOP_INSTR;
                            fd_valid_next = 1'b0;
                        end
                    end else if (squash_reg) begin
                        squash_next = 1'b0;
                        state_next  = ST_REQ;
                        if (!stall) begin
                            fd_ir_next    = NOP_INSTR;
                            fd_valid_next = 1'b0;
                        end
                    end else if (stall) begin
                        hb_load    = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        fd_ir_next    = imem.imem_rdata;
                        fd_pc_next    = pc_prev;
                        fd_valid_next = 1'b1;
                        req           = 1'b1;
                        pc_next       = pc_inc;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        fd_ir_next    = hb_ir;
                        fd_pc_next    = hb_pc;
                        fd_valid_next = hb_full;
                        hb_clear      = 1'b1;
                        req           = 1'b1;
                        pc_next       = pc_inc;
                        state_next    = ST_WAIT;
                    end
                end
                default: state_next = ST_START;
            endcase
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_reg;
    assign fd_ir          = fd_ir_reg;
    assign fd_pc          = fd_pc_reg;
    assign fd_valid       = fd_valid_reg;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Bench for fetch_issue_unit: latency-variable memory model plus a request/delivery reference model.
module tb_fetch_issue_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic [31:0] fd_ir;
    logic [11:0] fd_pc;
    logic        fd_valid;

    always #5 clock = ~clock;

    fetch_issue_unit_if #(.PC_W(12)) imem_bus ();

    fetch_issue_unit #(.PC_W(12), .RESET_PC(12'h000)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem        (imem_bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fd_ir       (fd_ir),
        .fd_pc       (fd_pc),
        .fd_valid    (fd_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // memory model
    bit          mem_busy;
    int          mem_left;
    logic [11:0] mem_addr;
    int          lat;

    // reference model: what is in flight, parked, or pending issue
    logic [11:0] m_pc, m_out_addr, m_held_pc;
    bit          m_start, m_issue, m_out, m_stale, m_held;
    logic [31:0] exp_ir;
    logic [11:0] exp_pc;
    bit          exp_valid;

    bit          last_req;
    logic [11:0] last_addr;

    function automatic logic [31:0] word(input logic [11:0] a);
        return {a, 8'h5A, ~a};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pc = 12'h000; m_start = 1; m_issue = 0; m_out = 0; m_stale = 0; m_held = 0;
        exp_ir = 32'h0; exp_pc = 12'h000; exp_valid = 0;
    endtask

    task automatic step();
        bit          v, e_req, deliv;
        logic [11:0] e_addr;
        e_req = 0; deliv = 0; e_addr = m_pc;
        if (mem_busy) mem_left--;
        v = mem_busy && (mem_left == 0);
        if (v) mem_busy = 0;
        imem_bus.imem_valid = v;
        imem_bus.imem_rdata = v ? word(mem_addr) : $urandom;
        #1;
        if (!reset_n) begin
            model_reset();
            check_val("rst_fd_ir", fd_ir, 32'h0);
            check_val("rst_fd_pc", 32'(fd_pc), 32'h0);
            check_val("rst_fd_valid", 32'(fd_valid), 32'h0);
        end else if (redirect) begin
            exp_ir = 32'h0; exp_valid = 0; m_held = 0;
            if (m_out && !v) m_stale = 1;
            else begin m_out = 0; m_stale = 0; m_issue = 1; m_start = 0; end
            m_pc = redirect_pc;
        end else if (m_start) begin
            m_start = 0; m_issue = 1;
        end else if (m_issue) begin
            e_req = 1; e_addr = m_pc; m_issue = 0; m_out = 1; m_out_addr = m_pc; m_pc = m_pc + 12'd1;
        end else if (m_held) begin
            if (!stall) begin
                exp_ir = word(m_held_pc); exp_pc = m_held_pc; exp_valid = 1; deliv = 1; m_held = 0;
                e_req = 1; e_addr = m_pc; m_out = 1; m_out_addr = m_pc; m_pc = m_pc + 12'd1;
            end
        end else if (m_out) begin
            if (v && m_stale) begin
                m_out = 0; m_stale = 0; m_issue = 1;
                if (!stall) begin exp_ir = 32'h0; exp_valid = 0; end
            end else if (v && stall) begin
                m_held = 1; m_held_pc = m_out_addr; m_out = 0;
            end else if (v) begin
                exp_ir = word(m_out_addr); exp_pc = m_out_addr; exp_valid = 1; deliv = 1;
                e_req = 1; e_addr = m_pc; m_out_addr = m_pc; m_pc = m_pc + 12'd1;
            end else if (!stall) begin
                exp_ir = 32'h0; exp_valid = 0;
            end
        end
        last_req  = imem_bus.imem_req;
        last_addr = imem_bus.imem_addr;
        check_val("imem_req", 32'(last_req), 32'(e_req));
        if (e_req) check_val("imem_addr", 32'(last_addr), 32'(e_addr));
        if (last_req) begin mem_busy = 1; mem_left = lat; mem_addr = last_addr; end
        @(posedge clock);
        #1;
        check_val("fd_valid", 32'(fd_valid), 32'(exp_valid));
        check_val("fd_ir", fd_ir, exp_ir);
        if (exp_valid) check_val("fd_pc", 32'(fd_pc), 32'(exp_pc));
        if (deliv) $display("issue pc=%03h ir=%08h", exp_pc, exp_ir);
        @(negedge clock);
    endtask

    initial begin
        logic [11:0] p;
        logic [11:0] got [3];
        int          n;

        reset_n = 0; stall = 0; redirect = 0; redirect_pc = 12'h0; lat = 1;
        mem_busy = 0; mem_left = 0; mem_addr = 12'h0;
        imem_bus.imem_valid = 0; imem_bus.imem_rdata = 32'h0;
        model_reset();
        @(negedge clock);
        step(); step();
        reset_n = 1;

        // streaming from reset with 1-cycle memory
        step(); step();
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("seq_pc", 32'(fd_pc), k);
            check_val("seq_valid", 32'(fd_valid), 32'h1);
        end

        // stall across an arriving response
        p = fd_pc;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_hold", 32'(fd_pc), 32'(p));
        end
        stall = 0;
        step();
        check_val("stall_release", 32'(fd_pc), 32'(p + 12'd1));

        // redirect with a slow request outstanding
        lat = 3;
        step();
        redirect = 1; redirect_pc = 12'h040;
        step();
        redirect = 0;
        check_val("redir_flush", 32'(fd_valid), 32'h0);
        lat = 1;
        for (int i = 0; i < 12; i++) begin
            if (fd_valid) break;
            step();
        end
        check_val("redir_valid", 32'(fd_valid), 32'h1);
        check_val("redir_target", 32'(fd_pc), 32'h040);

        // redirect overrides stall
        step();
        stall = 1; redirect = 1; redirect_pc = 12'h123;
        step();
        check_val("redir_stall_ir", fd_ir, 32'h0);
        check_val("redir_stall_valid", 32'(fd_valid), 32'h0);
        stall = 0; redirect = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_req) break;
        end
        check_val("redir_stall_pc", 32'(last_addr), 32'h123);

        // PC wrap at the top of the address space
        step();
        redirect = 1; redirect_pc = 12'hFFE;
        step();
        redirect = 0;
        got[0] = 12'h555; got[1] = 12'h555; got[2] = 12'h555;
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            step();
            if (last_req) begin got[n] = last_addr; n++; end
        end
        check_val("wrap_0", 32'(got[0]), 32'hFFE);
        check_val("wrap_1", 32'(got[1]), 32'hFFF);
        check_val("wrap_2", 32'(got[2]), 32'h000);

        // reset while a request is in flight; its response lands after release
        lat = 2;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_req) break;
        end
        reset_n = 0;
        step();
        reset_n = 1;
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_req) break;
        end
        check_val("reset_restart", 32'(last_addr), 32'h000);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            lat         = $urandom_range(1, 4);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 12'($urandom);
            step();
        end
        stall = 0; redirect = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
